// File: rtl/oldland_dbus_pkg.sv
// Shared types and constants for the oldland data-bus controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package oldland_dbus_pkg;

  // Address field that selects the target region.
  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;

  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Request bundle registered onto a slave port.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  bytesel;
    logic        wr_en;
    logic [31:0] wr_val;
  } bus_req_t;

  // Timeout counter width; at least one bit even for tiny limits.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int TMO_CNT_W = tmo_cnt_w(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/oldland_bus_timeout.sv
// Clear/enable cycle counter flagging when a slave has been waited on too long.
// Latency: expired_o is combinational from the registered count.
// Backpressure: none; counts while en_i is high and holds once expired.
module oldland_bus_timeout
  import oldland_dbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = tmo_cnt_w(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Next count: clear wins over enable; saturate at the limit so the flag stays up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/oldland_dbus_ctrl.sv
// CPU data-bus controller: decodes RAM/IO region, runs one handshake, returns ack/error.
// Latency: cs one cycle after request; d_ack/d_error the cycle after slave response; unmapped error in 1 cycle.
// Backpressure: single outstanding; d_access is held until d_ack/d_error and must drop before the next request.
module oldland_dbus_ctrl
  import oldland_dbus_pkg::*;
#(
  parameter logic [3:0] RAM_REGION     = 4'h0,
  parameter logic [3:0] IO_REGION      = 4'h8,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU side
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  input  logic        d_access,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  // RAM slave
  output logic        ram_cs,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_bytesel,
  output logic        ram_wr_en,
  output logic [31:0] ram_wr_val,
  input  logic [31:0] ram_rd_data,
  input  logic        ram_ack,
  // IO slave
  output logic        io_cs,
  output logic [31:0] io_addr,
  output logic [3:0]  io_bytesel,
  output logic        io_wr_en,
  output logic [31:0] io_wr_val,
  input  logic [31:0] io_rd_data,
  input  logic        io_ack,
  input  logic        io_error
);

  state_e      state_q, state_d;
  logic        ram_cs_q, ram_cs_d;
  logic        io_cs_q, io_cs_d;
  bus_req_t    ram_req_q, ram_req_d;
  bus_req_t    io_req_q, io_req_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic        tmo_clr;
  logic        tmo_en;
  logic        tmo_expired;

  bus_req_t    req_in;
  logic [3:0]  region;

  assign req_in = '{addr: d_addr, bytesel: d_bytesel, wr_en: d_wr_en, wr_val: d_wr_val};
  assign region = d_addr[REGION_MSB:REGION_LSB];

  oldland_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  // Next-state and datapath decisions for the single-outstanding handshake.
  always_comb begin
    state_d   = state_q;
    ram_cs_d  = ram_cs_q;
    io_cs_d   = io_cs_q;
    ram_req_d = ram_req_q;
    io_req_d  = io_req_q;
    err_d     = err_q;
    data_d    = data_q;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (d_access) begin
          data_d = '0;
          if (region == RAM_REGION) begin
            ram_req_d = req_in;
            ram_cs_d  = 1'b1;
            tmo_clr   = 1'b1;
            state_d   = ST_BUSY;
          end else if (region == IO_REGION) begin
            io_req_d = req_in;
            io_cs_d  = 1'b1;
            tmo_clr  = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        tmo_en = 1'b1;
        // Priority: IO error, then selected-slave ack, then timeout.
        if (io_cs_q && io_error) begin
          err_d   = 1'b1;
          io_cs_d = 1'b0;
          state_d = ST_RESP;
        end else if (ram_cs_q && ram_ack) begin
          data_d   = ram_req_q.wr_en ? 32'h0 : ram_rd_data;
          ram_cs_d = 1'b0;
          state_d  = ST_RESP;
        end else if (io_cs_q && io_ack) begin
          data_d  = io_req_q.wr_en ? 32'h0 : io_rd_data;
          io_cs_d = 1'b0;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          err_d    = 1'b1;
          ram_cs_d = 1'b0;
          io_cs_d  = 1'b0;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        // Held request must drop before another is accepted.
        if (!d_access) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered slave-port / response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ram_cs_q  <= 1'b0;
      io_cs_q   <= 1'b0;
      ram_req_q <= '0;
      io_req_q  <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ram_cs_q  <= ram_cs_d;
      io_cs_q   <= io_cs_d;
      ram_req_q <= ram_req_d;
      io_req_q  <= io_req_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  assign d_ack   = (state_q == ST_RESP) && !err_q;
  assign d_error = (state_q == ST_RESP) && err_q;
  assign d_data  = d_ack ? data_q : 32'h0;

  assign ram_cs      = ram_cs_q;
  assign ram_addr    = ram_req_q.addr;
  assign ram_bytesel = ram_req_q.bytesel;
  assign ram_wr_en   = ram_req_q.wr_en;
  assign ram_wr_val  = ram_req_q.wr_val;

  assign io_cs      = io_cs_q;
  assign io_addr    = io_req_q.addr;
  assign io_bytesel = io_req_q.bytesel;
  assign io_wr_en   = io_req_q.wr_en;
  assign io_wr_val  = io_req_q.wr_val;

endmodule

// File: tb/tb_oldland_dbus_ctrl.sv
// Directed bench for oldland_dbus_ctrl with hand-computed expectations.
// Latency: samples outputs 1 ns after each rising edge.
// Backpressure: slave acks/errors driven by the bench per scenario.
module tb_oldland_dbus_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic        d_access;
  logic [31:0] d_data;
  logic        d_ack;
  logic        d_error;
  logic        ram_cs;
  logic [31:0] ram_addr;
  logic [3:0]  ram_bytesel;
  logic        ram_wr_en;
  logic [31:0] ram_wr_val;
  logic [31:0] ram_rd_data;
  logic        ram_ack;
  logic        io_cs;
  logic [31:0] io_addr;
  logic [3:0]  io_bytesel;
  logic        io_wr_en;
  logic [31:0] io_wr_val;
  logic [31:0] io_rd_data;
  logic        io_ack;
  logic        io_error;

  int tests_run = 0;
  int failures  = 0;

  oldland_dbus_ctrl #(
    .RAM_REGION    (4'h0),
    .IO_REGION     (4'h8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_addr     (d_addr),
    .d_bytesel  (d_bytesel),
    .d_wr_en    (d_wr_en),
    .d_wr_val   (d_wr_val),
    .d_access   (d_access),
    .d_data     (d_data),
    .d_ack      (d_ack),
    .d_error    (d_error),
    .ram_cs     (ram_cs),
    .ram_addr   (ram_addr),
    .ram_bytesel(ram_bytesel),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_val (ram_wr_val),
    .ram_rd_data(ram_rd_data),
    .ram_ack    (ram_ack),
    .io_cs      (io_cs),
    .io_addr    (io_addr),
    .io_bytesel (io_bytesel),
    .io_wr_en   (io_wr_en),
    .io_wr_val  (io_wr_val),
    .io_rd_data (io_rd_data),
    .io_ack     (io_ack),
    .io_error   (io_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] bs,
                       input logic we, input logic [31:0] val);
    d_addr    = addr;
    d_bytesel = bs;
    d_wr_en   = we;
    d_wr_val  = val;
    d_access  = 1'b1;
  endtask

  task automatic release_bus();
    d_access = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({d_ack, d_error, ram_cs, io_cs} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000", {d_ack, d_error, ram_cs, io_cs});
    end
    tests_run++;
    if ({d_data, ram_addr, io_addr, ram_wr_val, io_wr_val} !== 160'h0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {d_data, ram_addr, io_addr, ram_wr_val, io_wr_val});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ram_read();
    int cs_cycles = 0;
    int extra_acks = 0;
    issue(32'h0000_0040, 4'hF, 1'b0, 32'h0);
    tick();                                   // cycle 1
    tests_run++;
    if (ram_cs !== 1'b1 || io_cs !== 1'b0 || ram_addr !== 32'h0000_0040 || ram_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL ram_rd_c1: cs=%b io_cs=%b addr=%h we=%b want 1 0 00000040 0",
               ram_cs, io_cs, ram_addr, ram_wr_en);
    end
    if (ram_cs === 1'b1) cs_cycles++;
    for (int c = 2; c <= 4; c++) begin
      tick();
      if (ram_cs === 1'b1) cs_cycles++;
    end
    ram_ack     = 1'b1;                       // during cycle 4
    ram_rd_data = 32'hDEAD_BEEF;
    tick();                                   // cycle 5
    ram_ack     = 1'b0;
    ram_rd_data = 32'h0;
    tests_run++;
    if (cs_cycles != 4) begin
      failures++;
      $display("FAIL ram_rd_cs_len: got %0d want 4", cs_cycles);
    end
    tests_run++;
    if (d_ack !== 1'b1 || d_error !== 1'b0 || d_data !== 32'hDEAD_BEEF || ram_cs !== 1'b0) begin
      failures++;
      $display("FAIL ram_rd_ack: ack=%b err=%b data=%h cs=%b want 1 0 deadbeef 0",
               d_ack, d_error, d_data, ram_cs);
    end
    for (int c = 6; c <= 9; c++) begin
      tick();
      if (ram_cs !== 1'b0 || d_ack !== 1'b0 || d_error !== 1'b0) extra_acks++;
    end
    tests_run++;
    if (extra_acks != 0) begin
      failures++;
      $display("FAIL ram_rd_no_reissue: got %0d bad cycles want 0", extra_acks);
    end
    release_bus();
  endtask

  task automatic test_io_write();
    issue(32'h8000_0010, 4'b0011, 1'b1, 32'h0000_1234);
    tick();                                   // cycle 1
    tests_run++;
    if (io_cs !== 1'b1 || ram_cs !== 1'b0 || io_addr !== 32'h8000_0010 ||
        io_bytesel !== 4'b0011 || io_wr_val !== 32'h0000_1234 || io_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL io_wr_c1: cs=%b ram_cs=%b addr=%h bs=%b val=%h we=%b want 1 0 80000010 0011 00001234 1",
               io_cs, ram_cs, io_addr, io_bytesel, io_wr_val, io_wr_en);
    end
    io_ack     = 1'b1;
    io_rd_data = 32'hFFFF_FFFF;
    tick();                                   // cycle 2
    io_ack     = 1'b0;
    io_rd_data = 32'h0;
    tests_run++;
    if (d_ack !== 1'b1 || d_error !== 1'b0 || d_data !== 32'h0 || io_cs !== 1'b0) begin
      failures++;
      $display("FAIL io_wr_ack: ack=%b err=%b data=%h cs=%b want 1 0 00000000 0",
               d_ack, d_error, d_data, io_cs);
    end
    release_bus();
  endtask

  task automatic test_unmapped();
    int cs_seen = 0;
    issue(32'h4000_0000, 4'hF, 1'b0, 32'h0);
    tick();                                   // cycle 1
    if (ram_cs !== 1'b0 || io_cs !== 1'b0) cs_seen++;
    tests_run++;
    if (d_error !== 1'b1 || d_ack !== 1'b0 || d_data !== 32'h0) begin
      failures++;
      $display("FAIL unmapped_err: err=%b ack=%b data=%h want 1 0 00000000", d_error, d_ack, d_data);
    end
    tick();                                   // cycle 2
    if (ram_cs !== 1'b0 || io_cs !== 1'b0) cs_seen++;
    tests_run++;
    if (d_error !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_pulse: err=%b want 0", d_error);
    end
    tests_run++;
    if (cs_seen != 0) begin
      failures++;
      $display("FAIL unmapped_no_cs: got %0d cycles with cs want 0", cs_seen);
    end
    release_bus();
  endtask

  task automatic test_timeout();
    int cs_cycles = 0;
    int err_count = 0;
    int err_cycle = -1;
    issue(32'h0000_0100, 4'hF, 1'b0, 32'h0);
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (ram_cs === 1'b1) cs_cycles++;
      if (d_error === 1'b1) begin
        err_count++;
        err_cycle = c;
      end
    end
    tests_run++;
    if (cs_cycles != 16) begin
      failures++;
      $display("FAIL timeout_cs_len: got %0d want 16", cs_cycles);
    end
    tests_run++;
    if (err_count != 1 || err_cycle != 17) begin
      failures++;
      $display("FAIL timeout_err: count=%0d cycle=%0d want 1 at 17", err_count, err_cycle);
    end
    release_bus();
  endtask

  task automatic test_io_ack_error();
    issue(32'h8000_0020, 4'hF, 1'b0, 32'h0);
    tick();                                   // cycle 1
    io_ack     = 1'b1;
    io_error   = 1'b1;
    io_rd_data = 32'hA5A5_A5A5;
    tick();                                   // cycle 2
    io_ack     = 1'b0;
    io_error   = 1'b0;
    io_rd_data = 32'h0;
    tests_run++;
    if (d_error !== 1'b1 || d_ack !== 1'b0 || d_data !== 32'h0 || io_cs !== 1'b0) begin
      failures++;
      $display("FAIL io_ack_err: err=%b ack=%b data=%h cs=%b want 1 0 00000000 0",
               d_error, d_ack, d_data, io_cs);
    end
    release_bus();
  endtask

  task automatic test_ack_at_timeout();
    issue(32'h0000_0200, 4'hF, 1'b0, 32'h0);
    tick();                                   // cycle 1
    io_ack   = 1'b1;                          // unselected slave, ignored
    io_error = 1'b1;
    tick();                                   // cycle 2
    io_ack   = 1'b0;
    io_error = 1'b0;
    tests_run++;
    if (ram_cs !== 1'b1 || d_error !== 1'b0 || d_ack !== 1'b0) begin
      failures++;
      $display("FAIL ignore_unselected: cs=%b err=%b ack=%b want 1 0 0", ram_cs, d_error, d_ack);
    end
    for (int c = 3; c <= 16; c++) tick();
    tests_run++;
    if (ram_cs !== 1'b1) begin
      failures++;
      $display("FAIL tmo_edge_cs16: cs=%b want 1", ram_cs);
    end
    ram_ack     = 1'b1;                       // the timeout cycle
    ram_rd_data = 32'hCAFE_0001;
    tick();                                   // cycle 17
    ram_ack     = 1'b0;
    ram_rd_data = 32'h0;
    tests_run++;
    if (d_ack !== 1'b1 || d_error !== 1'b0 || d_data !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL tmo_edge_ack: ack=%b err=%b data=%h want 1 0 cafe0001", d_ack, d_error, d_data);
    end
    release_bus();
  endtask

  task automatic test_reset_busy();
    issue(32'h0000_0300, 4'hC, 1'b1, 32'h0000_0055);
    tick();                                   // cycle 1
    tests_run++;
    if (ram_cs !== 1'b1 || ram_wr_val !== 32'h0000_0055) begin
      failures++;
      $display("FAIL rst_busy_pre: cs=%b val=%h want 1 00000055", ram_cs, ram_wr_val);
    end
    #2;
    rst_n = 1'b0;
    #1;                                       // no clock edge in between
    tests_run++;
    if ({ram_cs, io_cs, d_ack, d_error} !== 4'b0000 ||
        {ram_addr, ram_bytesel, ram_wr_en, ram_wr_val, d_data} !== 101'h0) begin
      failures++;
      $display("FAIL rst_busy_async: ctl=%b addr=%h bs=%b we=%b val=%h data=%h want all 0",
               {ram_cs, io_cs, d_ack, d_error}, ram_addr, ram_bytesel, ram_wr_en, ram_wr_val, d_data);
    end
    d_access = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(32'h0000_0044, 4'hF, 1'b0, 32'h0);
    tick();                                   // cycle 1
    tests_run++;
    if (ram_cs !== 1'b1 || ram_addr !== 32'h0000_0044) begin
      failures++;
      $display("FAIL rst_fresh_cs: cs=%b addr=%h want 1 00000044", ram_cs, ram_addr);
    end
    ram_ack     = 1'b1;
    ram_rd_data = 32'h1357_9BDF;
    tick();                                   // cycle 2
    ram_ack     = 1'b0;
    ram_rd_data = 32'h0;
    tests_run++;
    if (d_ack !== 1'b1 || d_error !== 1'b0 || d_data !== 32'h1357_9BDF) begin
      failures++;
      $display("FAIL rst_fresh_ack: ack=%b err=%b data=%h want 1 0 13579bdf", d_ack, d_error, d_data);
    end
    release_bus();
  endtask

  initial begin
    d_addr      = '0;
    d_bytesel   = '0;
    d_wr_en     = 1'b0;
    d_wr_val    = '0;
    d_access    = 1'b0;
    ram_rd_data = '0;
    ram_ack     = 1'b0;
    io_rd_data  = '0;
    io_ack      = 1'b0;
    io_error    = 1'b0;
    rst_n       = 1'b0;

    test_reset();
    test_ram_read();
    test_io_write();
    test_unmapped();
    test_timeout();
    test_io_ack_error();
    test_ack_at_timeout();
    test_reset_busy();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
